// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared sizes, idle key and opcode constants for the ALU arbiter slice
//
// Contents:
//   KEY_SIZE, OPCODE_SIZE, OPERAND_SIZE : default widths for the ALU-facing buses
//   KEY_IDLE                            : key value meaning "no operation" (ALU bubble)
//   alu_opcode_e                        : opcode encoding understood by the shared ALU
package alu_pkg;

    localparam int KEY_SIZE     = 8;
    localparam int OPCODE_SIZE  = 3;
    localparam int OPERAND_SIZE = 32;

    localparam logic [KEY_SIZE-1:0] KEY_IDLE = '0;

    typedef enum logic [OPCODE_SIZE-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } alu_opcode_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot grant selection, round-robin or fixed priority
//
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN
//   undefined : round-robin, search starts at ptr_i+1 modulo N
//   defined   : fixed priority, lowest index wins, ptr_i port removed
//
// Ports:
//   ptr_i  in   index of the last granted requester (round-robin build only)
//   req_i  in   N-bit request vector (already masked for eligibility)
//   gnt_o  out  N-bit one-hot grant, all zero when no request
module rr_arbiter #(
    parameter int N = 4
) (
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic [$clog2(N)-1:0] ptr_i,
`endif
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

`else

    localparam int IDXW = $clog2(N);

    logic            found;
    logic [IDXW-1:0] idx;

    // Walk N positions starting one past the last winner; the last position
    // visited is the previous winner itself, so a lone requester is re-granted.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int s = 1; s <= N; s++) begin
            idx = IDXW'((int'(ptr_i) + s) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one keyed, variable-latency ALU between NCH client channels
//
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-low reset
//   req_i        in   per-channel request level
//   op_i         in   packed opcodes, channel i at [i*OPCW +: OPCW]
//   A_i, B_i     in   packed operands, channel i at [i*OPW +: OPW]
//   gnt_o        out  one-cycle grant pulse (combinational in the grant cycle)
//   busy_o       out  channel has an operation in flight
//   res_valid_o  out  one-cycle result pulse per channel
//   res_o        out  result shared by all channels, holds between returns
//   alu_op_o, alu_key_o, alu_A_o, alu_B_o  out  registered issue to the ALU
//   alu_key_i, alu_O_i                     in   returning key and result from the ALU
//   err_o        out  sticky protocol error (bad or unexpected return key)
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int OPW  = OPERAND_SIZE,
    parameter int OPCW = OPCODE_SIZE,
    parameter int KEYW = KEY_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      req_i,
    input  logic [NCH*OPCW-1:0] op_i,
    input  logic [NCH*OPW-1:0]  A_i,
    input  logic [NCH*OPW-1:0]  B_i,
    output logic [NCH-1:0]      gnt_o,
    output logic [NCH-1:0]      busy_o,
    output logic [NCH-1:0]      res_valid_o,
    output logic [OPW-1:0]      res_o,
    output logic [OPCW-1:0]     alu_op_o,
    output logic [KEYW-1:0]     alu_key_o,
    output logic [OPW-1:0]      alu_A_o,
    output logic [OPW-1:0]      alu_B_o,
    input  logic [KEYW-1:0]     alu_key_i,
    input  logic [OPW-1:0]      alu_O_i,
    output logic                err_o
);

    localparam logic [KEYW-1:0] KEY_NONE = KEYW'(KEY_IDLE);

    logic [NCH-1:0]  busy_q, busy_d;
    logic [NCH-1:0]  res_valid_q, res_valid_d;
    logic [OPW-1:0]  res_q, res_d;
    logic [OPCW-1:0] alu_op_q, alu_op_d;
    logic [KEYW-1:0] alu_key_q, alu_key_d;
    logic [OPW-1:0]  alu_a_q, alu_a_d;
    logic [OPW-1:0]  alu_b_q, alu_b_d;
    logic            err_q, err_d;

    logic [NCH-1:0]  eligible;
    logic [NCH-1:0]  gnt;
    logic [NCH-1:0]  ret_hit;
    logic [NCH-1:0]  ret_ok;

    // A channel with an operation outstanding cannot be granted again; the
    // busy bit is the registered one, so a channel whose result returns this
    // cycle only becomes eligible the cycle after.
    assign eligible = req_i & ~busy_q;

`ifdef ALU_ARB_FIXED_PRIO_EN

    rr_arbiter #(
        .N (NCH)
    ) u_rr_arbiter (
        .req_i (eligible),
        .gnt_o (gnt)
    );

`else

    localparam int IDXW = $clog2(NCH);

    logic [IDXW-1:0] ptr_q, ptr_d;

    rr_arbiter #(
        .N (NCH)
    ) u_rr_arbiter (
        .ptr_i (ptr_q),
        .req_i (eligible),
        .gnt_o (gnt)
    );

    // The pointer remembers the last winner and only moves on a grant.
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                ptr_d = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= IDXW'(NCH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

    // Decode the returning key against every channel; only a hit on a busy
    // channel is a legal return. Key values above NCH never hit.
    always_comb begin
        ret_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            ret_hit[i] = (alu_key_i == KEYW'(i + 1));
        end
        ret_ok = ret_hit & busy_q;
    end

    always_comb begin
        busy_d      = busy_q;
        res_valid_d = '0;
        res_d       = res_q;
        err_d       = err_q;
        alu_key_d   = KEY_NONE;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;

        // Return path
        if (alu_key_i != KEY_NONE) begin
            if (|ret_ok) begin
                res_d       = alu_O_i;
                res_valid_d = ret_ok;
            end else begin
                err_d = 1'b1;
            end
        end

        // Grant path; a granted channel is never busy, so it cannot collide
        // with the channel being retired in the same cycle.
        busy_d = (busy_q & ~ret_ok) | gnt;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                alu_key_d = KEYW'(i + 1);
                alu_op_d  = op_i[i*OPCW +: OPCW];
                alu_a_d   = A_i[i*OPW +: OPW];
                alu_b_d   = B_i[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            res_valid_q <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            alu_key_q   <= KEY_NONE;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            err_q       <= err_d;
            alu_key_q   <= alu_key_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
        end
    end

    // The grant is combinational, so it is forced low while reset is asserted.
    assign gnt_o       = gnt & {NCH{rst}};
    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign res_o       = res_q;
    assign alu_key_o   = alu_key_q;
    assign alu_op_o    = alu_op_q;
    assign alu_A_o     = alu_a_q;
    assign alu_B_o     = alu_b_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with directed and randomized scenarios
module tb_alu_arbiter;

    localparam int NCH  = 4;
    localparam int OPW  = 32;
    localparam int OPCW = 3;
    localparam int KEYW = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      req_i;
    logic [NCH*OPCW-1:0] op_i;
    logic [NCH*OPW-1:0]  A_i;
    logic [NCH*OPW-1:0]  B_i;
    logic [NCH-1:0]      gnt_o;
    logic [NCH-1:0]      busy_o;
    logic [NCH-1:0]      res_valid_o;
    logic [OPW-1:0]      res_o;
    logic [OPCW-1:0]     alu_op_o;
    logic [KEYW-1:0]     alu_key_o;
    logic [OPW-1:0]      alu_A_o;
    logic [OPW-1:0]      alu_B_o;
    logic [KEYW-1:0]     alu_key_i;
    logic [OPW-1:0]      alu_O_i;
    logic                err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NCH  (NCH),
        .OPW  (OPW),
        .OPCW (OPCW),
        .KEYW (KEYW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .op_i        (op_i),
        .A_i         (A_i),
        .B_i         (B_i),
        .gnt_o       (gnt_o),
        .busy_o      (busy_o),
        .res_valid_o (res_valid_o),
        .res_o       (res_o),
        .alu_op_o    (alu_op_o),
        .alu_key_o   (alu_key_o),
        .alu_A_o     (alu_A_o),
        .alu_B_o     (alu_B_o),
        .alu_key_i   (alu_key_i),
        .alu_O_i     (alu_O_i),
        .err_o       (err_o)
    );

    // Reference ALU behaviour used to predict each client's result.
    function automatic logic [OPW-1:0] alu_ref(input logic [OPCW-1:0] op,
                                               input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return a;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int c, input logic [OPCW-1:0] op,
                          input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        op_i[c*OPCW +: OPCW] = op;
        A_i[c*OPW +: OPW]    = a;
        B_i[c*OPW +: OPW]    = b;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_i     = '0;
        op_i      = '0;
        A_i       = '0;
        B_i       = '0;
        alu_key_i = '0;
        alu_O_i   = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_i     = 4'b1111;
        op_i      = '1;
        A_i       = '1;
        B_i       = '1;
        alu_key_i = '0;
        alu_O_i   = '0;
        @(posedge clk);
        #2;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt_o); end
        n_checks++; if (busy_o !== 4'b0000) begin n_fail++; $display("FAIL reset_busy got=%b exp=0000", busy_o); end
        n_checks++; if (res_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_rv got=%b exp=0000", res_valid_o); end
        n_checks++; if (alu_key_o !== 8'd0) begin n_fail++; $display("FAIL reset_key got=%0d exp=0", alu_key_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
        n_checks++; if (res_o !== 32'd0) begin n_fail++; $display("FAIL reset_res got=%h exp=0", res_o); end
        n_checks++; if ({alu_op_o, alu_A_o, alu_B_o} !== '0) begin n_fail++; $display("FAIL reset_alu_bus got=%h/%h/%h exp=0", alu_op_o, alu_A_o, alu_B_o); end
    endtask

    // All four channels request continuously: one grant per cycle in index order.
    task automatic test_round_robin();
        logic [NCH-1:0] e;
        do_reset();
        for (int c = 0; c < NCH; c++) set_ch(c, 3'd0, OPW'(100 + c), OPW'(c));
        req_i = 4'b1111;
        for (int k = 0; k < NCH; k++) begin
            #1;
            e = 4'(1 << k);
            n_checks++; if (gnt_o !== e) begin n_fail++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt_o, e); end
            tick();
            n_checks++; if (alu_key_o !== KEYW'(k + 1)) begin n_fail++; $display("FAIL rr_key%0d got=%0d exp=%0d", k, alu_key_o, k + 1); end
            n_checks++; if (alu_A_o !== OPW'(100 + k)) begin n_fail++; $display("FAIL rr_A%0d got=%0d exp=%0d", k, alu_A_o, 100 + k); end
            e = 4'((1 << (k + 1)) - 1);
            n_checks++; if (busy_o !== e) begin n_fail++; $display("FAIL rr_busy%0d got=%b exp=%b", k, busy_o, e); end
        end
        #1;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL rr_all_busy_gnt got=%b exp=0000", gnt_o); end
        tick();
        n_checks++; if (alu_key_o !== 8'd0) begin n_fail++; $display("FAIL rr_bubble_key got=%0d exp=0", alu_key_o); end
        n_checks++; if (alu_A_o !== OPW'(103)) begin n_fail++; $display("FAIL rr_bubble_hold got=%0d exp=103", alu_A_o); end
        alu_key_i = 8'd1;
        alu_O_i   = 32'd100;
        #1;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL rr_no_bypass got=%b exp=0000", gnt_o); end
        tick();
        alu_key_i = 8'd0;
        n_checks++; if (res_valid_o !== 4'b0001) begin n_fail++; $display("FAIL rr_ret_rv got=%b exp=0001", res_valid_o); end
        n_checks++; if (busy_o !== 4'b1110) begin n_fail++; $display("FAIL rr_ret_busy got=%b exp=1110", busy_o); end
        #1;
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL rr_regrant got=%b exp=0001", gnt_o); end
        tick();
        req_i = '0;
        n_checks++; if (alu_key_o !== 8'd1) begin n_fail++; $display("FAIL rr_regrant_key got=%0d exp=1", alu_key_o); end
    endtask

    task automatic test_single_add();
        do_reset();
        set_ch(2, 3'd0, 32'd7, 32'd5);
        req_i = 4'b0100;
        #1;
        n_checks++; if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL add_gnt got=%b exp=0100", gnt_o); end
        tick();
        req_i = '0;
        n_checks++; if ({alu_key_o, alu_op_o, alu_A_o, alu_B_o} !== {8'd3, 3'd0, 32'd7, 32'd5}) begin n_fail++; $display("FAIL add_issue got=%0d/%0d/%0d/%0d exp=3/0/7/5", alu_key_o, alu_op_o, alu_A_o, alu_B_o); end
        n_checks++; if (busy_o !== 4'b0100) begin n_fail++; $display("FAIL add_busy got=%b exp=0100", busy_o); end
        tick();
        alu_key_i = 8'd3;
        alu_O_i   = 32'd12;
        tick();
        alu_key_i = 8'd0;
        n_checks++; if (res_valid_o !== 4'b0100) begin n_fail++; $display("FAIL add_rv got=%b exp=0100", res_valid_o); end
        n_checks++; if (res_o !== 32'd12) begin n_fail++; $display("FAIL add_res got=%0d exp=12", res_o); end
        n_checks++; if (busy_o !== 4'b0000) begin n_fail++; $display("FAIL add_busy_clr got=%b exp=0000", busy_o); end
        tick();
        n_checks++; if (res_valid_o !== 4'b0000) begin n_fail++; $display("FAIL add_rv_pulse got=%b exp=0000", res_valid_o); end
        n_checks++; if (res_o !== 32'd12) begin n_fail++; $display("FAIL add_res_hold got=%0d exp=12", res_o); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        set_ch(0, 3'd2, 32'hFF, 32'h0B);
        set_ch(3, 3'd4, 32'h10, 32'h3C);
        req_i = 4'b1001;
        tick();
        tick();
        req_i = '0;
        n_checks++; if (busy_o !== 4'b1001) begin n_fail++; $display("FAIL ooo_busy got=%b exp=1001", busy_o); end
        alu_key_i = 8'd4;
        alu_O_i   = 32'd44;
        tick();
        n_checks++; if (res_valid_o !== 4'b1000 || res_o !== 32'd44) begin n_fail++; $display("FAIL ooo_first got=%b/%0d exp=1000/44", res_valid_o, res_o); end
        alu_key_i = 8'd1;
        alu_O_i   = 32'd11;
        tick();
        alu_key_i = 8'd0;
        n_checks++; if (res_valid_o !== 4'b0001 || res_o !== 32'd11) begin n_fail++; $display("FAIL ooo_second got=%b/%0d exp=0001/11", res_valid_o, res_o); end
        n_checks++; if (busy_o !== 4'b0000) begin n_fail++; $display("FAIL ooo_busy_clr got=%b exp=0000", busy_o); end
    endtask

    // ch1 and ch3 request, ch1's result returns the cycle after each grant:
    // ch3 only wins the cycle ch1 is busy, afterwards it stays busy.
    task automatic test_return_pattern();
        logic [NCH-1:0] exp_tbl [6];
        exp_tbl[0] = 4'b0010;
        exp_tbl[1] = 4'b1000;
        exp_tbl[2] = 4'b0010;
        exp_tbl[3] = 4'b0000;
        exp_tbl[4] = 4'b0010;
        exp_tbl[5] = 4'b0000;
        do_reset();
        req_i = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            alu_key_i = busy_o[1] ? 8'd2 : 8'd0;
            alu_O_i   = OPW'(c);
            #1;
            n_checks++; if (gnt_o !== exp_tbl[c]) begin n_fail++; $display("FAIL pattern_gnt%0d got=%b exp=%b", c, gnt_o, exp_tbl[c]); end
            tick();
        end
        req_i     = '0;
        alu_key_i = '0;
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL pattern_err got=%b exp=0", err_o); end
    endtask

    task automatic test_errors();
        do_reset();
        alu_key_i = 8'd6;
        alu_O_i   = 32'd99;
        tick();
        alu_key_i = 8'd0;
        n_checks++; if (res_valid_o !== 4'b0000) begin n_fail++; $display("FAIL err_big_rv got=%b exp=0000", res_valid_o); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_big got=%b exp=1", err_o); end
        n_checks++; if (res_o !== 32'd0) begin n_fail++; $display("FAIL err_big_res got=%0d exp=0", res_o); end
        repeat (3) tick();
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", err_o); end
        do_reset();
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_cleared got=%b exp=0", err_o); end
        alu_key_i = 8'd5;
        tick();
        alu_key_i = 8'd0;
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_key5 got=%b exp=1", err_o); end
        do_reset();
        alu_key_i = 8'd2;
        tick();
        alu_key_i = 8'd0;
        n_checks++; if (res_valid_o !== 4'b0000 || err_o !== 1'b1) begin n_fail++; $display("FAIL err_idle got=%b/%b exp=0000/1", res_valid_o, err_o); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        req_i = 4'b0011;
        tick();
        tick();
        req_i = '0;
        n_checks++; if (busy_o !== 4'b0011) begin n_fail++; $display("FAIL midop_busy got=%b exp=0011", busy_o); end
        rst = 1'b0;
        #1;
        n_checks++; if (busy_o !== 4'b0000 || alu_key_o !== 8'd0) begin n_fail++; $display("FAIL midop_async got=%b/%0d exp=0000/0", busy_o, alu_key_o); end
        @(posedge clk);
        #2;
        rst       = 1'b1;
        alu_key_i = 8'd1;
        alu_O_i   = 32'd5;
        tick();
        alu_key_i = 8'd0;
        n_checks++; if (res_valid_o !== 4'b0000 || err_o !== 1'b1) begin n_fail++; $display("FAIL midop_stale got=%b/%b exp=0000/1", res_valid_o, err_o); end
    endtask

    // Random clients and a random-latency, out-of-order ALU, compared cycle by
    // cycle against a transaction-level model of the arbitration rules.
    task automatic test_random();
        logic [NCH-1:0]  m_busy;
        logic [NCH-1:0]  exp_gnt_v;
        logic [NCH-1:0]  exp_rv;
        logic [OPW-1:0]  m_res;
        logic [OPW-1:0]  exp_res [NCH];
        logic [OPCW-1:0] m_op;
        logic [OPW-1:0]  m_a;
        logic [OPW-1:0]  m_b;
        logic [KEYW-1:0] m_key;
        int              m_ptr;
        int              g;
        int              c;
        int              kk;
        int              ri;
        int              pk [$];
        logic [OPW-1:0]  pr [$];
        int              pd [$];

        do_reset();
        m_busy = '0;
        m_ptr  = NCH - 1;
        m_key  = '0;
        m_op   = '0;
        m_a    = '0;
        m_b    = '0;
        m_res  = '0;
        for (int i = 0; i < NCH; i++) exp_res[i] = '0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if (req_i[i]) begin
                    if ($urandom_range(15) == 0) req_i[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    set_ch(i, OPCW'($urandom_range(7)), $urandom, $urandom);
                    req_i[i] = 1'b1;
                end
            end

            alu_key_i = '0;
            alu_O_i   = $urandom;
            ri        = -1;
            for (int j = 0; j < pd.size(); j++) begin
                if (pd[j] <= cyc && (ri < 0 || $urandom_range(1) == 0)) ri = j;
            end
            if (ri >= 0) begin
                alu_key_i = KEYW'(pk[ri]);
                alu_O_i   = pr[ri];
                pk.delete(ri);
                pr.delete(ri);
                pd.delete(ri);
            end
            #1;

            g = -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            for (int s = 0; s < NCH; s++) begin
                if (g < 0 && req_i[s] && !m_busy[s]) g = s;
            end
`else
            for (int s = 1; s <= NCH; s++) begin
                c = (m_ptr + s) % NCH;
                if (g < 0 && req_i[c] && !m_busy[c]) g = c;
            end
`endif
            exp_gnt_v = (g >= 0) ? 4'(1 << g) : 4'b0000;
            n_checks++; if (gnt_o !== exp_gnt_v) begin n_fail++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, gnt_o, exp_gnt_v); end

            exp_rv = '0;
            kk     = int'(alu_key_i);
            if (kk >= 1 && kk <= NCH && m_busy[kk-1]) begin
                exp_rv[kk-1] = 1'b1;
                m_busy[kk-1] = 1'b0;
                m_res        = exp_res[kk-1];
            end
            if (g >= 0) begin
                m_busy[g]  = 1'b1;
                m_ptr      = g;
                m_key      = KEYW'(g + 1);
                m_op       = op_i[g*OPCW +: OPCW];
                m_a        = A_i[g*OPW +: OPW];
                m_b        = B_i[g*OPW +: OPW];
                exp_res[g] = alu_ref(m_op, m_a, m_b);
            end else begin
                m_key = '0;
            end

            tick();
            if (g >= 0) req_i[g] = 1'b0;

            n_checks++; if ({alu_key_o, alu_op_o, alu_A_o, alu_B_o} !== {m_key, m_op, m_a, m_b}) begin n_fail++; $display("FAIL rand_issue cyc=%0d got=%0d/%0d/%h/%h exp=%0d/%0d/%h/%h", cyc, alu_key_o, alu_op_o, alu_A_o, alu_B_o, m_key, m_op, m_a, m_b); end
            n_checks++; if (busy_o !== m_busy) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy_o, m_busy); end
            n_checks++; if (res_valid_o !== exp_rv) begin n_fail++; $display("FAIL rand_rv cyc=%0d got=%b exp=%b", cyc, res_valid_o, exp_rv); end
            n_checks++; if (res_o !== m_res) begin n_fail++; $display("FAIL rand_res cyc=%0d got=%h exp=%h", cyc, res_o, m_res); end
            n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rand_err cyc=%0d got=%b exp=0", cyc, err_o); end

            if (alu_key_o != '0) begin
                pk.push_back(int'(alu_key_o));
                pr.push_back(alu_ref(alu_op_o, alu_A_o, alu_B_o));
                pd.push_back(cyc + 1 + $urandom_range(1, 4));
            end
        end
        req_i     = '0;
        alu_key_i = '0;
    endtask

    initial begin
        rst       = 1'b0;
        req_i     = '0;
        op_i      = '0;
        A_i       = '0;
        B_i       = '0;
        alu_key_i = '0;
        alu_O_i   = '0;
        test_reset();
        test_round_robin();
        test_single_add();
        test_out_of_order();
        test_return_pattern();
        test_errors();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
